// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the common baud divisor.
package uart_pkg;

  // 12 MHz PLL clock / 115200 baud; the transmitter uses the same value.
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Single-entry valid/ready byte channel from the UART receiver to the MMIO bus.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_sync_ff.sv
// N-stage synchroniser for asynchronous inputs; every stage resets to 1.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rxd, samples mid-bit, delivers bytes on a
// single-entry valid/ready buffer and pulses frame_err / overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  uart_rx_if.master   rx,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic           rxd_s;
  uart_rx_state_t state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shreg, shreg_n;
  logic           stop_ok, stop_bad;
  logic           deliver_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (rxd),
    .q      (rxd_s)
  );

  // Frame state, bit timing counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  // Next-state logic: start validation, mid-bit data sampling, stop check.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxd_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n     = '0;
          shreg_n   = {rxd_s, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (rxd_s) begin
            stop_ok = 1'b1;
            state_n = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output buffer: delivery one cycle after a good stop bit; a same-cycle
  // drain lets the new byte replace the pending one instead of overrunning.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      deliver_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      deliver_q <= stop_ok;
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (deliver_q) begin
        if (!rx_valid_q || rx.rx_ready) begin
          rx_data_q  <= shreg;
          rx_valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid_q && rx.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = rx_data_q;
  assign rx.rx_valid = rx_valid_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized run
// compared against a frame-level model of the serial line.
module tb_uart_rx;

  localparam int CLKS = 104;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + CLKS / 2 + 9 * CLKS + 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rxd = 1'b1;
  logic frame_err, overrun, busy;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CLKS), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rx        (rx_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int both_cnt = 0;
  logic [7:0] got_q[$];
  bit done;

  // Pulse counters and handshake log, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1 && overrun === 1'b1) both_cnt++;
      if (rx_if.rx_valid === 1'b1 && rx_if.rx_ready === 1'b1) got_q.push_back(rx_if.rx_data);
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    fe_cnt = 0;
    ov_cnt = 0;
    both_cnt = 0;
    got_q.delete();
  endtask

  // Line level of frame bit i: start 0, data LSB first, then stop.
  function automatic logic line_bit(logic [7:0] b, logic stop, int i);
    if (i == 0) return 1'b0;
    if (i == 9) return stop;
    return b[i-1];
  endfunction

  task automatic send_byte(logic [7:0] b, logic stop);
    for (int i = 0; i < 10; i++) begin
      rxd = line_bit(b, stop, i);
      repeat (CLKS) tick();
    end
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (4) tick();
    total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
    total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    resetn = 1'b1;
    repeat (2) tick();
    clear_counts();
  endtask

  task automatic test_basic_a5();
    int lat;
    clear_counts();
    rx_if.rx_ready = 1'b0;
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (rx_if.rx_valid !== 1'b1 && lat < 3 * 10 * CLKS) begin
          tick();
          lat++;
        end
      end
    join
    total++; if (rx_if.rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", rx_if.rx_data); end
    total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL a5_valid got=%b exp=1", rx_if.rx_valid); end
    total++; if (lat < LAT - 2 || lat > LAT + 2) begin bad++; $display("FAIL a5_latency got=%0d exp=%0d+-2", lat, LAT); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d exp=0", fe_cnt); end
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL a5_drain got=%b exp=0", rx_if.rx_valid); end
  endtask

  task automatic test_glitch();
    int drop_t;
    bit seen_hi;
    clear_counts();
    drop_t = 0;
    seen_hi = 1'b0;
    rxd = 1'b0;
    for (int t = 1; t <= 300; t++) begin
      tick();
      if (t == 20) rxd = 1'b1;
      if (busy === 1'b1) seen_hi = 1'b1;
      if (seen_hi && busy === 1'b0) begin
        drop_t = t;
        break;
      end
    end
    total++; if (drop_t == 0 || drop_t > CLKS / 2 + SYNC + 2) begin bad++; $display("FAIL glitch_busy_drop got=%0d exp<=%0d", drop_t, CLKS / 2 + SYNC + 2); end
    repeat (CLKS) tick();
    total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", rx_if.rx_valid); end
    total++; if (fe_cnt + ov_cnt !== 0) begin bad++; $display("FAIL glitch_flags got=%0d exp=0", fe_cnt + ov_cnt); end
  endtask

  task automatic test_break();
    clear_counts();
    rx_if.rx_ready = 1'b1;
    send_byte(8'h3C, 1'b0);
    rxd = 1'b0;
    repeat (3 * CLKS) tick();
    rxd = 1'b1;
    repeat (CLKS) tick();
    send_byte(8'h55, 1'b1);
    repeat (CLKS) tick();
    rx_if.rx_ready = 1'b0;
    total++; if (fe_cnt !== 1) begin bad++; $display("FAIL break_frame_err got=%0d exp=1", fe_cnt); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL break_count got=%0d exp=1", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 8'h55) begin bad++; $display("FAIL break_data got=%h exp=55", got_q[0]); end
    end
  endtask

  task automatic test_overrun();
    clear_counts();
    rx_if.rx_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (4) tick();
    total++; if (rx_if.rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h exp=11", rx_if.rx_data); end
    total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", rx_if.rx_valid); end
    total++; if (ov_cnt !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ov_cnt); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL ovr_frame_err got=%0d exp=0", fe_cnt); end
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    total++; if (rx_if.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b exp=0", rx_if.rx_valid); end
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h11) begin bad++; $display("FAIL ovr_handshake got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    int falls;
    bit prev_busy;
    clear_counts();
    rx_if.rx_ready = 1'b0;
    falls = 0;
    prev_busy = 1'b0;
    fork
      begin
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
      end
      begin
        for (int t = 0; t < 2 * 10 * CLKS + 100; t++) begin
          tick();
          if (prev_busy && busy === 1'b0) falls++;
          prev_busy = (busy === 1'b1);
          if (falls == 2) begin
            rx_if.rx_ready = 1'b1;
            tick();
            rx_if.rx_ready = 1'b0;
            break;
          end
        end
      end
    join
    total++; if (falls !== 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", falls); end
    total++; if (rx_if.rx_data !== 8'h22) begin bad++; $display("FAIL b2b_data got=%h exp=22", rx_if.rx_data); end
    total++; if (rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", rx_if.rx_valid); end
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL b2b_overrun got=%0d exp=0", ov_cnt); end
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
    else begin
      total++; if (got_q[0] !== 8'h11 || got_q[1] !== 8'h22) begin bad++; $display("FAIL b2b_order got=%h,%h exp=11,22", got_q[0], got_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pb;
    clear_counts();
    rx_if.rx_ready = 1'b0;
    pb = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      rxd = line_bit(pb, 1'b1, i);
      repeat (CLKS) tick();
    end
    rxd = line_bit(pb, 1'b1, 5);
    repeat (CLKS / 2) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    rxd = 1'b1;
    total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data got=%h exp=00", rx_if.rx_data); end
    total++; if (rx_if.rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL mid_reset_flags got=%b%b%b exp=000", rx_if.rx_valid, frame_err, overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    repeat (2 * CLKS) tick();
    send_byte(8'h80, 1'b1);
    repeat (4) tick();
    total++; if (rx_if.rx_data !== 8'h80 || rx_if.rx_valid !== 1'b1) begin bad++; $display("FAIL mid_recv got=%h/%b exp=80/1", rx_if.rx_data, rx_if.rx_valid); end
    total++; if (fe_cnt !== 0) begin bad++; $display("FAIL mid_frame_err got=%0d exp=0", fe_cnt); end
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    int nbad;
    clear_counts();
    nbad = 0;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          logic [7:0] b;
          logic st;
          b = 8'($urandom);
          st = ($urandom_range(0, 3) != 0);
          send_byte(b, st);
          if (st) exp_q.push_back(b);
          else nbad++;
          repeat ($urandom_range(CLKS, 3 * CLKS)) tick();
        end
        repeat (20) tick();
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_if.rx_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    rx_if.rx_ready = 1'b1;
    tick();
    rx_if.rx_ready = 1'b0;
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
    total++; if (fe_cnt !== nbad) begin bad++; $display("FAIL rand_frame_err got=%0d exp=%0d", fe_cnt, nbad); end
    total++; if (ov_cnt !== 0) begin bad++; $display("FAIL rand_overrun got=%0d exp=0", ov_cnt); end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL rand_flag_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    test_reset();
    test_basic_a5();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
